// File: rtl/dna_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dna_pkg : state codes, residue-mask decode and gap constants shared by the
//           forward cell units and the traceback engine.
// Revision: 1.0
// ----------------------------------------------------------------------------
package dna_pkg;

  typedef enum logic [2:0] {
    ST_M    = 3'd0,
    ST_IXY  = 3'd1,
    ST_IYZ  = 3'd2,
    ST_IXZ  = 3'd3,
    ST_IX   = 3'd4,
    ST_IY   = 3'd5,
    ST_IZ   = 3'd6,
    ST_STOP = 3'd7
  } state_e;

  localparam logic [2:0] STATE_STOP = 3'd7;

  localparam int G0 = 10;
  localparam int GE = 1;

  // bit2 = A residue, bit1 = B residue, bit0 = C residue; STOP consumes nothing
  function automatic logic [2:0] state_mask(input logic [2:0] s);
    logic [2:0] m;
    m = 3'b000;
    case (state_e'(s))
      ST_M:    m = 3'b111;
      ST_IXY:  m = 3'b110;
      ST_IYZ:  m = 3'b011;
      ST_IXZ:  m = 3'b101;
      ST_IX:   m = 3'b100;
      ST_IY:   m = 3'b010;
      ST_IZ:   m = 3'b001;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/traceback_3d_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// traceback_3d_if : valid/ready alignment-column stream.
// Revision: 1.0
// ----------------------------------------------------------------------------
interface traceback_3d_if #(
  parameter int LEN_W = 6
) ();

  logic             col_valid;
  logic             col_ready;
  logic [2:0]       col_mask;
  logic [LEN_W-1:0] col_i;
  logic [LEN_W-1:0] col_j;
  logic [LEN_W-1:0] col_k;

  modport master (
    output col_valid, col_mask, col_i, col_j, col_k,
    input  col_ready
  );

  modport slave (
    input  col_valid, col_mask, col_i, col_j, col_k,
    output col_ready
  );

endinterface
`default_nettype wire

// File: rtl/traceback_3d.sv
`default_nettype none
// ----------------------------------------------------------------------------
// traceback_3d : walks predecessor pointers from the end cell back to the
//                origin, emitting one alignment column per step (end first).
// Revision: 1.0
// ----------------------------------------------------------------------------
module traceback_3d
  import dna_pkg::*;
#(
  parameter int LEN_W = 6,
  parameter int CNT_W = LEN_W + 2
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             start,
  input  wire logic [LEN_W-1:0] len_i,
  input  wire logic [LEN_W-1:0] len_j,
  input  wire logic [LEN_W-1:0] len_k,
  input  wire logic [2:0]       end_state,
  output logic                  ptr_rd_en,
  output logic [LEN_W-1:0]      ptr_addr_i,
  output logic [LEN_W-1:0]      ptr_addr_j,
  output logic [LEN_W-1:0]      ptr_addr_k,
  output logic [2:0]            ptr_addr_s,
  input  wire logic [2:0]       ptr_rd_data,
  traceback_3d_if.master        col,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CNT_W-1:0]      col_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EMIT  = 3'd3,
    S_FIN   = 3'd4
  } fsm_e;

  fsm_e             r_state;
  logic [LEN_W-1:0] r_i, r_j, r_k;
  logic [2:0]       r_cur;
  logic [2:0]       r_nxt;
  logic [2:0]       r_mask;
  logic             r_ptr_rd_en;
  logic             r_col_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic [2:0]       w_mask;
  logic             w_bad;
  logic [LEN_W-1:0] w_ni, w_nj, w_nk;
  logic             w_origin;
  logic             w_start_origin;

  assign w_mask = state_mask(r_cur);

  // A mask bit on an exhausted sequence would walk below the origin
  assign w_bad = (r_cur == STATE_STOP)
               || (w_mask[2] && (r_i == '0))
               || (w_mask[1] && (r_j == '0))
               || (w_mask[0] && (r_k == '0));

  assign w_ni = r_i - {{(LEN_W-1){1'b0}}, r_mask[2]};
  assign w_nj = r_j - {{(LEN_W-1){1'b0}}, r_mask[1]};
  assign w_nk = r_k - {{(LEN_W-1){1'b0}}, r_mask[0]};
  assign w_origin       = (w_ni == '0) && (w_nj == '0) && (w_nk == '0);
  assign w_start_origin = (len_i == '0) && (len_j == '0) && (len_k == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_i         <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_cur       <= '0;
      r_nxt       <= '0;
      r_mask      <= '0;
      r_ptr_rd_en <= 1'b0;
      r_col_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_ptr_rd_en <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_i    <= len_i;
            r_j    <= len_j;
            r_k    <= len_k;
            r_cur  <= end_state;
            r_err  <= 1'b0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            if (w_start_origin) begin
              r_state <= S_FIN;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state     <= S_FETCH;
              r_ptr_rd_en <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_nxt <= ptr_rd_data;
          if (w_bad) begin
            r_err   <= 1'b1;
            r_state <= S_FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_mask      <= w_mask;
            r_col_valid <= 1'b1;
            r_state     <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (col.col_ready) begin
            r_col_valid <= 1'b0;
            if (r_cnt != {CNT_W{1'b1}}) begin
              r_cnt <= r_cnt + 1'b1;
            end
            r_i   <= w_ni;
            r_j   <= w_nj;
            r_k   <= w_nk;
            r_cur <= r_nxt;
            // The pointer fetched at the last cell is meaningless at the origin
            if (w_origin) begin
              r_state <= S_FIN;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state     <= S_FETCH;
              r_ptr_rd_en <= 1'b1;
            end
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ptr_rd_en     = r_ptr_rd_en;
  assign ptr_addr_i    = r_i;
  assign ptr_addr_j    = r_j;
  assign ptr_addr_k    = r_k;
  assign ptr_addr_s    = r_cur;

  assign col.col_valid = r_col_valid;
  assign col.col_mask  = r_mask;
  assign col.col_i     = r_i;
  assign col.col_j     = r_j;
  assign col.col_k     = r_k;

  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;
  assign col_cnt       = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_traceback_3d.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_traceback_3d : directed traceback walks against a reference walk model.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_traceback_3d;

  localparam int LW = 6;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] len_i = '0, len_j = '0, len_k = '0;
  logic [2:0]    end_state = '0;
  logic          ptr_rd_en;
  logic [LW-1:0] pai, paj, pak;
  logic [2:0]    pas;
  logic [2:0]    ptr_rd_data = '0;
  logic          busy, done, err;
  logic [CW-1:0] col_cnt;

  traceback_3d_if #(.LEN_W(LW)) cif ();

  traceback_3d #(.LEN_W(LW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len_i      (len_i),
    .len_j      (len_j),
    .len_k      (len_k),
    .end_state  (end_state),
    .ptr_rd_en  (ptr_rd_en),
    .ptr_addr_i (pai),
    .ptr_addr_j (paj),
    .ptr_addr_k (pak),
    .ptr_addr_s (pas),
    .ptr_rd_data(ptr_rd_data),
    .col        (cif),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .col_cnt    (col_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mem[int];
  logic [20:0] exp_cols[$];
  logic [20:0] exp_reads[$];
  logic        exp_err;
  int          exp_cnt;
  int          stall_seen = 0;
  int          done_seen = 0;
  logic        prev_stall = 1'b0;
  logic [20:0] prev_fields = '0;
  logic [2:0]  mask_tbl[8] = '{3'b111, 3'b110, 3'b011, 3'b101, 3'b100, 3'b010, 3'b001, 3'b000};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp_v);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0h expected=none", name, act);
  endtask

  function automatic int key(input int i, input int j, input int k, input int s);
    return (i << 15) | (j << 9) | (k << 3) | s;
  endfunction

  // Reference walk: the reads, columns, final error and column count a run must produce
  task automatic model(input logic [5:0] li, input logic [5:0] lj, input logic [5:0] lk,
                       input logic [2:0] es);
    int i, j, k, cur, a;
    logic [2:0] m;
    i = li; j = lj; k = lk; cur = es;
    exp_cols.delete();
    exp_reads.delete();
    exp_err = 1'b0;
    exp_cnt = 0;
    while (i + j + k != 0) begin
      exp_reads.push_back({i[5:0], j[5:0], k[5:0], cur[2:0]});
      m = mask_tbl[cur];
      if (cur == 7 || (m[2] && i == 0) || (m[1] && j == 0) || (m[0] && k == 0)) begin
        exp_err = 1'b1;
        break;
      end
      exp_cols.push_back({m, i[5:0], j[5:0], k[5:0]});
      exp_cnt++;
      a = key(i, j, k, cur);
      i -= int'(m[2]);
      j -= int'(m[1]);
      k -= int'(m[0]);
      cur = mem.exists(a) ? mem[a] : 0;
    end
  endtask

  // Pointer memory: data valid exactly one cycle after the strobe, junk otherwise
  initial begin
    forever begin
      @(negedge clk);
      if (ptr_rd_en) begin
        int a, v;
        a = key(int'(pai), int'(paj), int'(pak), int'(pas));
        v = mem.exists(a) ? mem[a] : 0;
        @(posedge clk);
        #1 ptr_rd_data = v[2:0];
        @(posedge clk);
        #1 ptr_rd_data = 3'd7;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (ptr_rd_en) begin
        if (exp_reads.size() == 0) fail_now("unexpected_read", {pai, paj, pak, pas});
        else check("read_addr", {pai, paj, pak, pas}, exp_reads.pop_front());
      end
      if (cif.col_valid) check("no_read_in_emit", ptr_rd_en, 0);
      if (prev_stall)
        check("stall_hold", {cif.col_valid, cif.col_mask, cif.col_i, cif.col_j, cif.col_k},
              {1'b1, prev_fields});
      if (cif.col_valid && cif.col_ready) begin
        if (exp_cols.size() == 0) fail_now("extra_column", {cif.col_mask, cif.col_i, cif.col_j, cif.col_k});
        else check("column", {cif.col_mask, cif.col_i, cif.col_j, cif.col_k}, exp_cols.pop_front());
      end
      if (cif.col_valid && !cif.col_ready) stall_seen++;
      prev_stall  = cif.col_valid && !cif.col_ready;
      prev_fields = {cif.col_mask, cif.col_i, cif.col_j, cif.col_k};
      if (done) begin
        done_seen++;
        check("err_at_done", err, exp_err);
        check("cnt_at_done", col_cnt, exp_cnt);
        check("busy_at_done", busy, 0);
        check("cols_left", exp_cols.size(), 0);
        check("reads_left", exp_reads.size(), 0);
      end
    end
  end

  task automatic run(input logic [5:0] li, input logic [5:0] lj, input logic [5:0] lk,
                     input logic [2:0] es, input int stall, input int exp_lat);
    int left, lat;
    bit got;
    model(li, lj, lk, es);
    left = stall; stall_seen = 0; got = 0; lat = 0;
    len_i = li; len_j = lj; len_k = lk; end_state = es;
    start = 1'b1;
    cif.col_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      lat = c;
      if (done) begin
        got = 1;
        break;
      end
      check("busy_during_run", busy, 1);
      if (cif.col_valid && left > 0) begin
        left--;
        cif.col_ready = 1'b0;
      end else begin
        cif.col_ready = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!got) begin
      fail_now("done_timeout", lat);
    end else begin
      check("latency", lat, exp_lat);
      @(posedge clk);
      #1;
      check("done_pulse", done, 0);
      check("err_sticky", err, exp_err);
      check("cnt_hold", col_cnt, exp_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int ds;
    cif.col_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {ptr_rd_en, pai, paj, pak, pas, cif.col_valid, cif.col_mask,
                            cif.col_i, cif.col_j, cif.col_k, busy, done, err, col_cnt}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_outputs", {ptr_rd_en, cif.col_valid, busy, done, err, col_cnt}, 0);

    mem.delete();
    run(6'd1, 6'd1, 6'd1, 3'd0, 0, 4);

    mem[key(2, 1, 1, 0)] = 4;
    model(6'd2, 6'd1, 6'd1, 3'd0);
    check("model_mixed_col0", exp_cols[0], {3'b111, 6'd2, 6'd1, 6'd1});
    check("model_mixed_col1", exp_cols[1], {3'b100, 6'd1, 6'd0, 6'd0});
    check("model_mixed_cnt", exp_cnt, 2);
    run(6'd2, 6'd1, 6'd1, 3'd0, 0, 7);

    run(6'd2, 6'd1, 6'd1, 3'd0, 5, 12);
    check("stall_cycles", stall_seen, 5);

    run(6'd0, 6'd0, 6'd0, 3'd0, 0, 1);

    model(6'd0, 6'd1, 6'd1, 3'd4);
    check("model_underflow", {exp_err, 8'(exp_cnt), 8'(exp_reads.size())}, {1'b1, 8'd0, 8'd1});
    run(6'd0, 6'd1, 6'd1, 3'd4, 0, 3);

    mem.delete();
    mem[key(2, 1, 1, 0)] = 7;
    model(6'd2, 6'd1, 6'd1, 3'd0);
    check("model_stop", {exp_err, 8'(exp_cnt)}, {1'b1, 8'd1});
    run(6'd2, 6'd1, 6'd1, 3'd0, 0, 6);

    mem.delete();
    mem[key(3, 2, 2, 0)] = 1;
    mem[key(2, 1, 1, 1)] = 6;
    mem[key(1, 0, 1, 6)] = 4;
    model(6'd3, 6'd2, 6'd2, 3'd0);
    check("model_walk_col2", exp_cols[2], {3'b001, 6'd1, 6'd0, 6'd1});
    run(6'd3, 6'd2, 6'd2, 3'd0, 2, 15);

    mem.delete();
    mem[key(2, 1, 1, 0)] = 4;
    model(6'd2, 6'd1, 6'd1, 3'd0);
    len_i = 6'd2; len_j = 6'd1; len_k = 6'd1; end_state = 3'd0;
    cif.col_ready = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (cif.col_valid) break;
      @(posedge clk);
      #1;
    end
    check("mid_walk_valid", cif.col_valid, 1);
    @(posedge clk);
    #1;
    ds = done_seen;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst_mid_walk", {ptr_rd_en, pai, paj, pak, pas, cif.col_valid, cif.col_mask,
                           cif.col_i, cif.col_j, cif.col_k, busy, done, err, col_cnt}, 0);
    repeat (5) @(posedge clk);
    #1;
    check("no_done_after_rst", done_seen, ds);
    cif.col_ready = 1'b1;
    run(6'd1, 6'd1, 6'd1, 3'd0, 0, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
